// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch port and a data port share one synchronous RAM.
// One grant per cycle, data has priority unless fetch has waited STARVE_LIMIT grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] ram_address,
    output logic [3:0]  ram_byteena,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DATA  = 2'd2
    } tag_t;

    tag_t             tag;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             fetch_wins;

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        starved    = (starve_cnt == LIMIT);
        fetch_wins = i_req && (!d_req || starved);
        i_gnt      = reset_n && fetch_wins;
        d_gnt      = reset_n && d_req && !fetch_wins;
    end

    // Reads keep byteena at zero so bypass bytes can never disturb ram_q.
    always_comb begin
        ram_address = '0;
        ram_byteena = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (i_gnt) begin
            ram_address = i_addr;
        end else if (d_gnt) begin
            ram_address = d_addr;
            if (d_we) begin
                ram_wren    = 1'b1;
                ram_byteena = d_be;
                ram_data    = d_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag        <= TAG_NONE;
            starve_cnt <= '0;
        end else begin
            if (i_gnt) begin
                tag <= TAG_FETCH;
            end else if (d_gnt) begin
                tag <= TAG_DATA;
            end else begin
                tag <= TAG_NONE;
            end

            if (!i_req || i_gnt) begin
                starve_cnt <= '0;
            end else if (d_gnt && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // ram_q carries the word addressed last cycle, so the tag routes it.
    always_comb begin
        i_rvalid = (tag == TAG_FETCH);
        d_rvalid = (tag == TAG_DATA);
        i_rdata  = i_rvalid ? ram_q : '0;
        d_rdata  = d_rvalid ? ram_q : '0;
    end

endmodule
